// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed 8-digit hex seven-segment driver.
// The display word is latched at frame boundaries so that a frame never mixes
// two values. The scan runs one digit at a time, and the pin drive is
// registered one cycle behind the scan position.
module seg7_scan #(
  parameter int unsigned SCAN_DIV   = 100000,
  parameter bit          LZ_BLANK   = 1'b1,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  input  logic        blank,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  // Inactive pin levels for the board polarity.
  localparam logic [7:0] AN_OFF  = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = ACTIVE_LOW;

  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       digit_idx;
  logic [31:0]      shadow;

  logic        wrap_c;
  logic        frame_end_c;
  logic [4:0]  bit_base_c;
  logic [3:0]  nib_c;
  logic [6:0]  hex_c;
  logic        lead_zero_c;
  logic        lit_c;
  logic [7:0]  an_nxt_c;
  logic [6:0]  seg_nxt_c;

  assign wrap_c      = (div_cnt == DIV_LAST);
  assign frame_end_c = wrap_c && (digit_idx == 3'd7);
  assign bit_base_c  = {digit_idx, 2'b00};

  // Prescaler, digit position, frame latch and frame pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt    <= '0;
      digit_idx  <= 3'd0;
      shadow     <= 32'd0;
      frame_tick <= 1'b0;
    end else begin
      div_cnt    <= wrap_c ? '0 : div_cnt + DIV_W'(1);
      frame_tick <= frame_end_c;
      if (wrap_c) begin
        digit_idx <= digit_idx + 3'd1;
      end
      if (frame_end_c) begin
        shadow <= value;
      end
    end
  end

  // Hex digit to active-high {g,f,e,d,c,b,a} segment pattern.
  always_comb begin
    nib_c = shadow[bit_base_c +: 4];
    hex_c = 7'h00;
    case (nib_c)
      4'h0: hex_c = 7'h3F;
      4'h1: hex_c = 7'h06;
      4'h2: hex_c = 7'h5B;
      4'h3: hex_c = 7'h4F;
      4'h4: hex_c = 7'h66;
      4'h5: hex_c = 7'h6D;
      4'h6: hex_c = 7'h7D;
      4'h7: hex_c = 7'h07;
      4'h8: hex_c = 7'h7F;
      4'h9: hex_c = 7'h6F;
      4'hA: hex_c = 7'h77;
      4'hB: hex_c = 7'h7C;
      4'hC: hex_c = 7'h39;
      4'hD: hex_c = 7'h5E;
      4'hE: hex_c = 7'h79;
      4'hF: hex_c = 7'h71;
      default: hex_c = 7'h00;
    endcase
  end

  // Leading-zero and blank gating, then board polarity.
  always_comb begin
    lead_zero_c = LZ_BLANK && (digit_idx != 3'd0) &&
                  ((shadow >> bit_base_c) == 32'd0);
    lit_c       = !blank && !lead_zero_c;
    an_nxt_c    = lit_c ? 8'(8'd1 << digit_idx) : 8'h00;
    seg_nxt_c   = lit_c ? hex_c : 7'h00;
    an_nxt_c    = an_nxt_c ^ {8{ACTIVE_LOW}};
    seg_nxt_c   = seg_nxt_c ^ {7{ACTIVE_LOW}};
  end

  // Registered pin drive; the decimal point is never used.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= DP_OFF;
    end else begin
      an  <= an_nxt_c;
      seg <= seg_nxt_c;
      dp  <= DP_OFF;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: two instances (leading-zero blanking on and off) sharing
// inputs. An independent cycle-count model queues the expected pins at every
// clock edge; they are popped and compared on the following falling edge.
// Table vectors and hand-written sequences add frame-level checks.
module tb_seg7_scan;

  localparam int unsigned DIV = 4;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic [31:0] value = 32'd0;
  logic        blank = 1'b0;

  logic [7:0] an1, an2;
  logic [6:0] seg1, seg2;
  logic       dp1, dp2, ft1, ft2;

  seg7_scan #(.SCAN_DIV(DIV), .LZ_BLANK(1'b1), .ACTIVE_LOW(1'b1)) u_lz (
    .clk(clk), .rst(rst), .value(value), .blank(blank),
    .an(an1), .seg(seg1), .dp(dp1), .frame_tick(ft1)
  );

  seg7_scan #(.SCAN_DIV(DIV), .LZ_BLANK(1'b0), .ACTIVE_LOW(1'b1)) u_nolz (
    .clk(clk), .rst(rst), .value(value), .blank(blank),
    .an(an2), .seg(seg2), .dp(dp2), .frame_tick(ft2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // ---------------- scoreboard model ----------------
  typedef struct {
    logic [7:0] an1;
    logic [6:0] seg1;
    logic [7:0] an2;
    logic [6:0] seg2;
    logic       ft;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        m_e;
  exp_t        c_e;
  int unsigned m_cnt;
  int unsigned m_div;
  int unsigned m_idx;
  logic [31:0] m_shadow;
  logic [3:0]  m_nib;
  logic        m_lz;

  // Expected state after each edge, derived from the edge count since reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt    = 0;
      m_shadow = 32'd0;
      sb_q.delete();
    end else begin
      m_div    = m_cnt % DIV;
      m_idx    = (m_cnt / DIV) % 8;
      m_nib    = 4'(m_shadow >> (4 * m_idx));
      m_lz     = (m_idx != 0) && ((m_shadow >> (4 * m_idx)) == 32'd0);
      m_e.an2  = blank ? 8'hFF : 8'(~(8'd1 << m_idx));
      m_e.seg2 = blank ? 7'h7F : 7'(~hex7(m_nib));
      m_e.an1  = (blank || m_lz) ? 8'hFF : m_e.an2;
      m_e.seg1 = (blank || m_lz) ? 7'h7F : m_e.seg2;
      m_e.ft   = (m_div == DIV - 1) && (m_idx == 7);
      sb_q.push_back(m_e);
      if (m_e.ft) m_shadow = value;
      m_cnt++;
    end
  end

  // Compare pins on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_an1", 32'(an1), 32'hFF);
      chk("rst_seg1", 32'(seg1), 32'h7F);
      chk("rst_dp1", 32'(dp1), 32'h1);
      chk("rst_an2", 32'(an2), 32'hFF);
      chk("rst_ft1", 32'(ft1), 32'h0);
    end else if (sb_q.size() > 0) begin
      c_e = sb_q.pop_front();
      chk("sb_an1", 32'(an1), 32'(c_e.an1));
      chk("sb_seg1", 32'(seg1), 32'(c_e.seg1));
      chk("sb_an2", 32'(an2), 32'(c_e.an2));
      chk("sb_seg2", 32'(seg2), 32'(c_e.seg2));
      chk("sb_dp", 32'({dp1, dp2}), 32'h3);
      chk("sb_ft", 32'({ft1, ft2}), c_e.ft ? 32'h3 : 32'h0);
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [31:0]     v;
    logic [7:0][7:0] an;
    logic [7:0][6:0] seg;
  } vec_t;

  vec_t vecs[6];

  // Waits for the next frame pulse; n returns the falling edges consumed.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ft1 && n < 100);
    chk("tick_seen", 32'(ft1), 32'h1);
  endtask

  int n;
  int cnt_ft;
  int cnt_fe;

  initial begin
    vecs[0] = '{32'h00000000,
                {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFE},
                {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[1] = '{32'h12345678,
                {8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE},
                {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}};
    vecs[2] = '{32'h00000105,
                {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFB, 8'hFD, 8'hFE},
                {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h12}};
    vecs[3] = '{32'h0000ABCD,
                {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF7, 8'hFB, 8'hFD, 8'hFE},
                {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h03, 7'h46, 7'h21}};
    vecs[4] = '{32'hF0000000,
                {8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE},
                {7'h0E, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[5] = '{32'hFFFFFFFF,
                {8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE},
                {7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E}};

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // value = 0: one frame pulse and one lit "0" digit per 32 cycles.
    cnt_ft = 0;
    cnt_fe = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ft1) cnt_ft++;
      if (an1 == 8'hFE && seg1 == 7'h40) cnt_fe++;
    end
    chk("zero_ticks_per_64", 32'(cnt_ft), 32'd2);
    chk("zero_lit_per_64", 32'(cnt_fe), 32'd8);

    // Table vectors: each digit for a full frame.
    for (int i = 0; i < 6; i++) begin
      value = vecs[i].v;
      wait_tick(n);
      for (int d = 0; d < 8; d++) begin
        for (int k = 0; k < int'(DIV); k++) begin
          @(negedge clk);
          chk($sformatf("vec%0d_d%0d_an", i, d), 32'(an1), 32'(vecs[i].an[d]));
          chk($sformatf("vec%0d_d%0d_seg", i, d), 32'(seg1), 32'(vecs[i].seg[d]));
        end
      end
    end

    // Mid-frame change: the current frame keeps ABCD.
    value = 32'h0000ABCD;
    wait_tick(n);
    repeat (9) @(negedge clk);
    value = 32'h0000FFFF;
    repeat (4) @(negedge clk);
    chk("tear_d3_an", 32'(an1), 32'hF7);
    chk("tear_d3_seg", 32'(seg1), 32'h08);
    wait_tick(n);
    chk("tear_tick_an", 32'(an1), 32'hFF);
    @(negedge clk);
    chk("new_d0_an", 32'(an1), 32'hFE);
    chk("new_d0_seg", 32'(seg1), 32'h0E);

    // Blank for 10 cycles mid-frame; the scan phase must not slip.
    value = 32'h12345678;
    wait_tick(n);
    repeat (5) @(negedge clk);
    blank = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("blank_an1", 32'(an1), 32'hFF);
      chk("blank_an2", 32'(an2), 32'hFF);
    end
    blank = 1'b0;
    wait_tick(n);
    chk("blank_phase", 32'(n), 32'd17);

    // Reset pulse while digit 5 is lit.
    value = 32'hFFFFFFFF;
    wait_tick(n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (an2 != 8'hDF && n < 64);
    chk("reach_d5", 32'(an2), 32'hDF);
    #2 rst = 1'b1;
    #1;
    chk("async_an1", 32'(an1), 32'hFF);
    chk("async_seg1", 32'(seg1), 32'h7F);
    chk("async_an2", 32'(an2), 32'hFF);
    chk("async_dp", 32'(dp1), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_an1", 32'(an1), 32'hFE);
    chk("post_rst_seg1", 32'(seg1), 32'h40);
    chk("post_rst_an2", 32'(an2), 32'hFE);
    chk("post_rst_seg2", 32'(seg2), 32'h40);
    wait_tick(n);
    chk("post_rst_tick", 32'(n), 32'd31);
    @(negedge clk);
    chk("post_rst_frame1_seg", 32'(seg1), 32'h0E);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
